// File: rtl/ltsm_sb_msg_pkg.sv
// Sideband message codes and RX-calibration state encodings shared by the
// MBTRAIN RX-cal initiator and responder blocks.
package ltsm_sb_msg_pkg;

    localparam logic [3:0] MSG_NONE       = 4'b0000;
    localparam logic [3:0] MSG_START_REQ  = 4'b0001;
    localparam logic [3:0] MSG_START_RESP = 4'b0010;
    localparam logic [3:0] MSG_END_REQ    = 4'b0011;
    localparam logic [3:0] MSG_END_RESP   = 4'b0100;

    typedef enum logic [2:0] {
        RXC_IDLE            = 3'd0,
        RXC_WAIT_START_REQ  = 3'd1,
        RXC_SEND_START_RESP = 3'd2,
        RXC_WAIT_END_REQ    = 3'd3,
        RXC_SEND_END_RESP   = 3'd4,
        RXC_TEST_FINISHED   = 3'd5,
        RXC_TIMEOUT         = 3'd6
    } rx_cal_state_e;

    function automatic logic sb_msg_is(input logic       valid,
                                       input logic [3:0] msg,
                                       input logic [3:0] code);
        return valid && (msg == code);
    endfunction

endpackage

// File: rtl/ltsm_timeout_cnt.sv
// Saturating watchdog counter for MBTRAIN substates; expired flags the last
// running cycle before LIMIT so the owner can leave on the following edge.
module ltsm_timeout_cnt #(
    parameter int LIMIT = 8000,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != LIMIT_C)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = run && (r_cnt == LAST_C);

endmodule

// File: rtl/rx_cal_rx.sv
// Responder side of the MBTRAIN RX-calibration sideband handshake:
// START_REQ -> START_RESP, END_REQ -> END_RESP, then ack (or timeout).
module rx_cal_rx
    import ltsm_sb_msg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [3:0] i_decoded_sideband_message,
    input  logic       i_sideband_valid,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    output logic [3:0] o_sideband_message,
    output logic       o_valid_tx,
    output logic       o_test_ack,
    output logic       o_timeout
);

    rx_cal_state_e r_state;
    rx_cal_state_e w_state_nx;

    logic [3:0] r_msg;
    logic       r_valid_tx;
    logic       r_test_ack;
    logic       r_timeout;
    logic       r_end_pend;

    logic [3:0] w_msg_nx;
    logic       w_valid_tx_nx;
    logic       w_test_ack_nx;
    logic       w_timeout_nx;
    logic       w_end_pend_nx;

    logic w_start_req;
    logic w_end_req;
    logic w_tx_clear;
    logic w_run;
    logic w_clear;
    logic w_expired;

    assign w_start_req = sb_msg_is(i_sideband_valid, i_decoded_sideband_message, MSG_START_REQ);
    assign w_end_req   = sb_msg_is(i_sideband_valid, i_decoded_sideband_message, MSG_END_REQ);
    // The transmitter is done with our message only once the mux is not owned by RX.
    assign w_tx_clear  = i_busy_negedge_detected && !i_valid_rx;

    assign w_run   = (r_state == RXC_WAIT_START_REQ) || (r_state == RXC_SEND_START_RESP) ||
                     (r_state == RXC_WAIT_END_REQ)   || (r_state == RXC_SEND_END_RESP);
    assign w_clear = !i_en || (r_state == RXC_IDLE);

    ltsm_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .run     (w_run),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RXC_IDLE;
            r_msg      <= MSG_NONE;
            r_valid_tx <= 1'b0;
            r_test_ack <= 1'b0;
            r_timeout  <= 1'b0;
            r_end_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_msg      <= w_msg_nx;
            r_valid_tx <= w_valid_tx_nx;
            r_test_ack <= w_test_ack_nx;
            r_timeout  <= w_timeout_nx;
            r_end_pend <= w_end_pend_nx;
        end
    end

    // Valid/ready: o_valid_tx rises with the message and is held until the sideband
    // transmitter reports completion (busy negedge with RX not owning the mux); the
    // SEND_* state leaves on the cycle after the drop is visible.
    always_comb begin
        w_state_nx    = r_state;
        w_msg_nx      = r_msg;
        w_valid_tx_nx = r_valid_tx;
        w_test_ack_nx = r_test_ack;
        w_timeout_nx  = r_timeout;
        w_end_pend_nx = r_end_pend;

        if (!i_en) begin
            w_state_nx    = RXC_IDLE;
            w_msg_nx      = MSG_NONE;
            w_valid_tx_nx = 1'b0;
            w_test_ack_nx = 1'b0;
            w_timeout_nx  = 1'b0;
            w_end_pend_nx = 1'b0;
        end else begin
            case (r_state)
                RXC_IDLE: begin
                    w_state_nx = RXC_WAIT_START_REQ;
                end
                RXC_WAIT_START_REQ: begin
                    if (w_expired) begin
                        w_state_nx = RXC_TIMEOUT;
                    end else if (w_start_req) begin
                        w_state_nx    = RXC_SEND_START_RESP;
                        w_msg_nx      = MSG_START_RESP;
                        w_valid_tx_nx = 1'b1;
                    end
                end
                RXC_SEND_START_RESP: begin
                    if (w_end_req) begin
                        w_end_pend_nx = 1'b1;
                    end
                    if (w_expired) begin
                        w_state_nx = RXC_TIMEOUT;
                    end else if (!r_valid_tx) begin
                        w_state_nx = RXC_WAIT_END_REQ;
                    end else if (w_tx_clear) begin
                        w_valid_tx_nx = 1'b0;
                    end
                end
                RXC_WAIT_END_REQ: begin
                    if (w_expired) begin
                        w_state_nx = RXC_TIMEOUT;
                    end else if (w_end_req || r_end_pend) begin
                        w_state_nx    = RXC_SEND_END_RESP;
                        w_msg_nx      = MSG_END_RESP;
                        w_valid_tx_nx = 1'b1;
                        w_end_pend_nx = 1'b0;
                    end
                end
                RXC_SEND_END_RESP: begin
                    if (w_expired) begin
                        w_state_nx = RXC_TIMEOUT;
                    end else if (!r_valid_tx) begin
                        w_state_nx    = RXC_TEST_FINISHED;
                        w_test_ack_nx = 1'b1;
                        w_msg_nx      = MSG_NONE;
                    end else if (w_tx_clear) begin
                        w_valid_tx_nx = 1'b0;
                    end
                end
                RXC_TEST_FINISHED: begin
                    w_state_nx = RXC_TEST_FINISHED;
                end
                RXC_TIMEOUT: begin
                    w_state_nx = RXC_TIMEOUT;
                end
                default: begin
                    w_state_nx    = RXC_IDLE;
                    w_msg_nx      = MSG_NONE;
                    w_valid_tx_nx = 1'b0;
                    w_test_ack_nx = 1'b0;
                    w_timeout_nx  = 1'b0;
                    w_end_pend_nx = 1'b0;
                end
            endcase

            if (w_state_nx == RXC_TIMEOUT) begin
                w_msg_nx      = MSG_NONE;
                w_valid_tx_nx = 1'b0;
                w_timeout_nx  = 1'b1;
                w_end_pend_nx = 1'b0;
            end
        end
    end

    assign o_sideband_message = r_msg;
    assign o_valid_tx         = r_valid_tx;
    assign o_test_ack         = r_test_ack;
    assign o_timeout          = r_timeout;

endmodule

// File: tb/tb_rx_cal_rx.sv
// Bench for rx_cal_rx: nominal vector table, hand-written corner sequences and a
// randomized run against a milestone-level handshake model.
module tb_rx_cal_rx;

    localparam int TMO = 16;

    logic       clk;
    logic       rst;
    logic       i_en;
    logic [3:0] i_msg;
    logic       i_sbv;
    logic       i_busy;
    logic       i_vrx;
    logic [3:0] o_sideband_message;
    logic       o_valid_tx;
    logic       o_test_ack;
    logic       o_timeout;

    int n_cmp;
    int n_err;

    logic [6:0] exp_q[$];

    rx_cal_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_msg),
        .i_sideband_valid           (i_sbv),
        .i_busy_negedge_detected    (i_busy),
        .i_valid_rx                 (i_vrx),
        .o_sideband_message         (o_sideband_message),
        .o_valid_tx                 (o_valid_tx),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [3:0] msg;
        logic       sbv;
        logic       busy;
        logic       vrx;
        logic [3:0] e_msg;
        logic       e_vtx;
        logic       e_ack;
        logic       e_tmo;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic en, input logic [3:0] m, input logic sbv,
                                input logic busy, input logic vrx, input logic [3:0] em,
                                input logic ev, input logic ea, input logic et);
        vec_t v;
        v.en = en; v.msg = m; v.sbv = sbv; v.busy = busy; v.vrx = vrx;
        v.e_msg = em; v.e_vtx = ev; v.e_ack = ea; v.e_tmo = et;
        return v;
    endfunction

    // driver tasks
    task automatic drive(input logic en, input logic [3:0] m, input logic sbv,
                         input logic busy, input logic vrx);
        i_en = en; i_msg = m; i_sbv = sbv; i_busy = busy; i_vrx = vrx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] em, input logic ev,
                       input logic ea, input logic et);
        n_cmp++;
        if ({o_sideband_message, o_valid_tx, o_test_ack, o_timeout} !== {em, ev, ea, et}) begin
            n_err++;
            $display("FAIL %s: got msg=%b vtx=%b ack=%b tmo=%b, want msg=%b vtx=%b ack=%b tmo=%b",
                     name, o_sideband_message, o_valid_tx, o_test_ack, o_timeout, em, ev, ea, et);
        end
    endtask

    // Reference model: tracks handshake milestones (0 idle, 1 awaiting start,
    // 2 answering start, 3 awaiting end, 4 answering end, 5 done, 6 timed out)
    // and the elapsed cycles since the handshake began.
    int         m_stage;
    int         m_age;
    bit         m_early;
    logic [3:0] m_msg;
    logic       m_vtx;
    logic       m_ack;
    logic       m_tmo;

    task automatic model_step(input logic en, input logic [3:0] m, input logic sbv,
                              input logic busy, input logic vrx);
        bit start_seen;
        bit end_seen;
        bit tx_done;
        start_seen = sbv && (m == 4'd1);
        end_seen   = sbv && (m == 4'd3);
        tx_done    = busy && !vrx;
        if (!en) begin
            m_stage = 0; m_age = 0; m_early = 0;
            m_msg = 4'd0; m_vtx = 0; m_ack = 0; m_tmo = 0;
            return;
        end
        if (m_stage == 0) begin
            m_stage = 1; m_age = 0;
            return;
        end
        if (m_stage >= 5) return;
        if (m_stage == 2 && end_seen) m_early = 1;
        if (m_age == TMO - 1) begin
            m_stage = 6; m_tmo = 1; m_vtx = 0; m_msg = 4'd0; m_early = 0;
            return;
        end
        m_age++;
        if (m_stage == 1) begin
            if (start_seen) begin m_stage = 2; m_msg = 4'd2; m_vtx = 1; end
        end else if (m_stage == 2 || m_stage == 4) begin
            if (!m_vtx) begin
                if (m_stage == 2) m_stage = 3;
                else begin m_stage = 5; m_ack = 1; m_msg = 4'd0; end
            end else if (tx_done) begin
                m_vtx = 0;
            end
        end else if (m_stage == 3) begin
            if (end_seen || m_early) begin
                m_stage = 4; m_msg = 4'd4; m_vtx = 1; m_early = 0;
            end
        end
    endtask

    initial begin
        logic [6:0] e;
        logic [3:0] rm;
        logic       ren, rsbv, rbusy, rvrx;

        n_cmp = 0;
        n_err = 0;

        // nominal handshake with mux contention, then abort via i_en
        tbl[0]  = mk(1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        tbl[1]  = mk(1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        tbl[2]  = mk(1, 4'd1, 1, 0, 0, 4'd2, 1, 0, 0);
        tbl[3]  = mk(1, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
        tbl[4]  = mk(1, 4'd0, 0, 1, 0, 4'd2, 0, 0, 0);
        tbl[5]  = mk(1, 4'd0, 0, 0, 0, 4'd2, 0, 0, 0);
        tbl[6]  = mk(1, 4'd0, 0, 0, 0, 4'd2, 0, 0, 0);
        tbl[7]  = mk(1, 4'd3, 1, 0, 0, 4'd4, 1, 0, 0);
        tbl[8]  = mk(1, 4'd0, 0, 0, 0, 4'd4, 1, 0, 0);
        tbl[9]  = mk(1, 4'd0, 0, 1, 1, 4'd4, 1, 0, 0);
        tbl[10] = mk(1, 4'd0, 0, 1, 0, 4'd4, 0, 0, 0);
        tbl[11] = mk(1, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
        tbl[12] = mk(1, 4'd1, 1, 0, 0, 4'd0, 0, 1, 0);
        tbl[13] = mk(1, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
        tbl[14] = mk(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        tbl[15] = mk(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);

        rst = 1'b1;
        drive(0, 4'd0, 0, 0, 0);
        #12;
        chk("reset", 4'd0, 0, 0, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].msg, tbl[i].sbv, tbl[i].busy, tbl[i].vrx);
            tick();
            chk($sformatf("vec%0d", i), tbl[i].e_msg, tbl[i].e_vtx, tbl[i].e_ack, tbl[i].e_tmo);
        end

        // early END_REQ while START_RESP is still being sent
        drive(1, 4'd0, 0, 0, 0); tick();
        drive(1, 4'd1, 1, 0, 0); tick(); chk("early_start", 4'd2, 1, 0, 0);
        drive(1, 4'd3, 1, 0, 0); tick(); chk("early_endreq", 4'd2, 1, 0, 0);
        drive(1, 4'd0, 0, 1, 0); tick(); chk("early_clr", 4'd2, 0, 0, 0);
        drive(1, 4'd0, 0, 0, 0); tick(); chk("early_wait_entry", 4'd2, 0, 0, 0);
        tick();                          chk("early_pending_resp", 4'd4, 1, 0, 0);
        drive(1, 4'd0, 0, 1, 0); tick(); chk("early_end_clr", 4'd4, 0, 0, 0);
        drive(1, 4'd0, 0, 0, 0); tick(); chk("early_ack", 4'd0, 0, 1, 0);
        drive(0, 4'd0, 0, 0, 0); tick();

        // timeout with no START_REQ: exactly TMO cycles after leaving IDLE
        drive(1, 4'd0, 0, 0, 0); tick();
        for (int k = 1; k < TMO; k++) begin
            tick();
            chk($sformatf("tmo_wait%0d", k), 4'd0, 0, 0, 0);
        end
        tick(); chk("tmo_fire", 4'd0, 0, 0, 1);
        tick(); chk("tmo_hold", 4'd0, 0, 0, 1);
        drive(0, 4'd0, 0, 0, 0); tick(); chk("tmo_en_low", 4'd0, 0, 0, 0);

        // timeout beats an END_REQ arriving on the same edge
        drive(1, 4'd0, 0, 0, 0); tick();
        drive(1, 4'd1, 1, 0, 0); tick(); chk("prio_start", 4'd2, 1, 0, 0);
        drive(1, 4'd0, 0, 1, 0); tick();
        drive(1, 4'd0, 0, 0, 0); tick();
        for (int k = 4; k < TMO; k++) tick();
        chk("prio_pre", 4'd2, 0, 0, 0);
        drive(1, 4'd3, 1, 0, 0); tick(); chk("prio_tmo", 4'd0, 0, 0, 1);
        drive(0, 4'd0, 0, 0, 0); tick();

        // noise during WAIT_START_REQ
        drive(1, 4'd0, 0, 0, 0); tick();
        drive(1, 4'd3, 1, 0, 0); tick(); chk("noise_end", 4'd0, 0, 0, 0);
        drive(1, 4'd5, 1, 0, 0); tick(); chk("noise_5", 4'd0, 0, 0, 0);
        drive(1, 4'd1, 0, 0, 0); tick(); chk("noise_novalid", 4'd0, 0, 0, 0);
        drive(1, 4'd1, 1, 0, 0); tick(); chk("noise_then_start", 4'd2, 1, 0, 0);

        // abort in SEND_END_RESP
        drive(1, 4'd0, 0, 1, 0); tick();
        drive(1, 4'd0, 0, 0, 0); tick();
        drive(1, 4'd3, 1, 0, 0); tick(); chk("abort_endresp", 4'd4, 1, 0, 0);
        drive(0, 4'd0, 0, 0, 0); tick(); chk("abort_idle", 4'd0, 0, 0, 0);
        drive(1, 4'd0, 0, 0, 0); tick();
        drive(1, 4'd1, 1, 0, 0); tick(); chk("abort_restart", 4'd2, 1, 0, 0);

        // asynchronous reset between edges
        drive(1, 4'd0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 4'd0, 0, 0, 0);
        rst = 1'b0;
        tick();
        drive(1, 4'd1, 1, 0, 0); tick(); chk("after_rst", 4'd2, 1, 0, 0);

        // randomized run against the model
        drive(0, 4'd0, 0, 0, 0);
        model_step(0, 4'd0, 0, 0, 0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            ren  = ($urandom_range(0, 24) != 0);
            rsbv = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 5))
                0, 1:    rm = 4'd1;
                2, 3:    rm = 4'd3;
                4:       rm = 4'd0;
                default: rm = 4'($urandom_range(0, 15));
            endcase
            rbusy = ($urandom_range(0, 1) == 0);
            rvrx  = ($urandom_range(0, 3) == 0);
            drive(ren, rm, rsbv, rbusy, rvrx);
            model_step(ren, rm, rsbv, rbusy, rvrx);
            exp_q.push_back({m_msg, m_vtx, m_ack, m_tmo});
            tick();
            e = exp_q.pop_front();
            chk($sformatf("rand%0d", c), e[6:3], e[2], e[1], e[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
